av2_entropy_encoder: RTL and testbench

- Bitstream-side counterpart of the AV2 entropy decoder.
- Accepts variable-length codewords (code, length) from the symbol coder over a valid/ready handshake.
- Packs them MSB-first into DATA_WIDTH-bit bitstream words, emitted on a valid/ready interface of the same shape the decoder's bitstream input consumes.
- A flush pads the final partial word with zeros and closes the stream with a done pulse.

---
 rtl/av2_entropy_encoder_if.sv | 24 ++
 rtl/av2_entropy_encoder.sv | 116 +++++++++++
 tb/tb_av2_entropy_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/av2_entropy_encoder_if.sv
// Codeword input and bitstream output handshakes of the AV2 entropy encoder.
// The master modport is the encoder's view; slave is the surrounding environment.
interface av2_entropy_encoder_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_LEN    = 32
);
  logic [MAX_LEN-1:0]    symbol_code;
  logic [5:0]            symbol_len;
  logic                  symbol_valid;
  logic                  symbol_ready;
  logic [DATA_WIDTH-1:0] bitstream_data;
  logic                  bitstream_valid;
  logic                  bitstream_ready;

  modport master (
    input  symbol_code, symbol_len, symbol_valid, bitstream_ready,
    output symbol_ready, bitstream_data, bitstream_valid
  );

  modport slave (
    output symbol_code, symbol_len, symbol_valid, bitstream_ready,
    input  symbol_ready, bitstream_data, bitstream_valid
  );
endinterface

// File: rtl/av2_entropy_encoder.sv
// Packs right-aligned variable-length codewords MSB-first into DATA_WIDTH-bit bitstream words;
// a flush zero-pads the last partial word and ends the stream with a one-cycle done pulse.
module av2_entropy_encoder #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_LEN    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         flush_i,
  av2_entropy_encoder_if.master        bus_io,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [31:0]                  bit_count_o
);
  typedef enum logic [1:0] {StIdle, StActive, StFlush, StDone} state_e;

  localparam int unsigned        AccW     = DATA_WIDTH + MAX_LEN;
  localparam int unsigned        FillW    = $clog2(AccW);
  localparam logic [FillW-1:0]   WordFill = FillW'(DATA_WIDTH);
  localparam logic [FillW:0]     AccLen   = (FillW + 1)'(AccW);
  localparam logic [5:0]         MaxLen   = 6'(MAX_LEN);

  state_e                state_q, state_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [FillW-1:0]      fill_q, fill_d;
  logic [31:0]           bit_count_q, bit_count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic [5:0]            eff_len;
  logic [FillW-1:0]      eff_len_f;
  logic [AccW-1:0]       code_ext;
  logic [FillW:0]        shamt;
  logic                  sym_ready, accept, slot_free, word_ready, load;

  assign eff_len    = (bus_io.symbol_len > MaxLen) ? MaxLen : bus_io.symbol_len;
  assign eff_len_f  = FillW'(eff_len);
  assign code_ext   = {{DATA_WIDTH{1'b0}}, bus_io.symbol_code} & ~({AccW{1'b1}} << eff_len);
  // Accumulator is MSB-first: the new code lands right after the last valid bit.
  assign shamt      = AccLen - {1'b0, fill_q} - {1'b0, eff_len_f};
  assign sym_ready  = (state_q == StActive) && (fill_q < WordFill);
  assign accept     = bus_io.symbol_valid && sym_ready;
  assign slot_free  = !valid_q || bus_io.bitstream_ready;
  assign word_ready = fill_q >= WordFill;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    bit_count_d = bit_count_q;
    data_d      = data_q;
    valid_d     = valid_q;
    load        = 1'b0;
    if (valid_q && bus_io.bitstream_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StActive;
          acc_d       = '0;
          fill_d      = '0;
          bit_count_d = '0;
        end
      end
      StActive: begin
        if (accept) begin
          acc_d       = acc_q | (code_ext << shamt);
          fill_d      = fill_q + eff_len_f;
          bit_count_d = bit_count_q + 32'(eff_len);
        end
        load = word_ready && slot_free;
        if (flush_i) state_d = StFlush;
      end
      StFlush: begin
        // Full words drain first; a partial remainder leaves zero-padded by the shift.
        load = (fill_q != '0) && slot_free;
        if ((fill_q == '0) && !valid_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load) begin
      data_d  = acc_q[AccW-1 -: DATA_WIDTH];
      valid_d = 1'b1;
      acc_d   = acc_q << DATA_WIDTH;
      fill_d  = word_ready ? (fill_q - WordFill) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      fill_q      <= '0;
      bit_count_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      bit_count_q <= bit_count_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign bus_io.symbol_ready    = sym_ready;
  assign bus_io.bitstream_data  = data_q;
  assign bus_io.bitstream_valid = valid_q;
  assign busy_o                 = state_q != StIdle;
  assign done_o                 = state_q == StDone;
  assign bit_count_o            = bit_count_q;
endmodule

// File: tb/tb_av2_entropy_encoder.sv
// Directed bench for av2_entropy_encoder: packing, padding, clamping, backpressure and reset.
module tb_av2_entropy_encoder;
  localparam int unsigned DW = 128;
  localparam int unsigned ML = 32;
  localparam logic [DW-1:0] W1 = 128'h11111111_22222222_33333333_44444444;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] bit_count;

  int checks = 0;
  int fails  = 0;

  // Posedge monitor state, written only by the monitor process.
  int            cyc       = 0;
  int            vcyc      = 0;
  int            hs_cyc    = 0;
  int            done_cnt  = 0;
  int            done_cyc  = 0;
  int            flush_cyc = 0;
  logic [DW-1:0] words[$];

  av2_entropy_encoder_if #(.DATA_WIDTH(DW), .MAX_LEN(ML)) bus ();

  av2_entropy_encoder #(.DATA_WIDTH(DW), .MAX_LEN(ML)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .flush_i     (flush),
    .bus_io      (bus),
    .busy_o      (busy),
    .done_o      (done),
    .bit_count_o (bit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.bitstream_valid) vcyc = vcyc + 1;
    if (bus.bitstream_valid && bus.bitstream_ready) begin
      words.push_back(bus.bitstream_data);
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (flush) flush_cyc = cyc;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    bus.symbol_valid    = 1'b0;
    bus.symbol_code     = '0;
    bus.symbol_len      = '0;
    bus.bitstream_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_stream();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [31:0] code, input logic [5:0] len);
    int n = 0;
    bus.symbol_code  = code;
    bus.symbol_len   = len;
    bus.symbol_valid = 1'b1;
    while (!bus.symbol_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: symbol_ready stayed %0b, required 1", bus.symbol_ready);
    end
    @(negedge clk);
    bus.symbol_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.symbol_ready !== 1'b0) begin fails++;
      $display("FAIL reset_symbol_ready: got %0b want 0", bus.symbol_ready); end
    checks++; if (bus.bitstream_valid !== 1'b0) begin fails++;
      $display("FAIL reset_bitstream_valid: got %0b want 0", bus.bitstream_valid); end
    checks++; if (bus.bitstream_data !== '0) begin fails++;
      $display("FAIL reset_bitstream_data: got %h want 0", bus.bitstream_data); end
    checks++; if (done !== 1'b0) begin fails++;
      $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (bit_count !== 32'd0) begin fails++;
      $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
  endtask

  task automatic test_full_word();
    int wb, vb;
    do_reset();
    bus.bitstream_ready = 1'b1;
    wb = words.size();
    vb = vcyc;
    start_stream();
    send(32'h11111111, 6'd32);
    send(32'h22222222, 6'd32);
    send(32'h33333333, 6'd32);
    send(32'h44444444, 6'd32);
    checks++; if (bus.bitstream_valid !== 1'b0) begin fails++;
      $display("FAIL full_latency_early: valid %0b want 0", bus.bitstream_valid); end
    @(negedge clk);
    checks++; if (bus.bitstream_valid !== 1'b1) begin fails++;
      $display("FAIL full_latency_valid: valid %0b want 1", bus.bitstream_valid); end
    checks++; if (bus.bitstream_data !== W1) begin fails++;
      $display("FAIL full_data: got %h want %h", bus.bitstream_data, W1); end
    repeat (4) @(negedge clk);
    checks++; if (words.size() - wb !== 1) begin fails++;
      $display("FAIL full_word_count: got %0d want 1", words.size() - wb); end
    else begin
      checks++; if (words[wb] !== W1) begin fails++;
        $display("FAIL full_word: got %h want %h", words[wb], W1); end
    end
    checks++; if (vcyc - vb !== 1) begin fails++;
      $display("FAIL full_valid_cycles: got %0d want 1", vcyc - vb); end
    checks++; if (bit_count !== 32'd128) begin fails++;
      $display("FAIL full_bit_count: got %0d want 128", bit_count); end
    checks++; if (busy !== 1'b1) begin fails++;
      $display("FAIL full_busy: got %0b want 1", busy); end
  endtask

  task automatic test_flush_pad();
    int wb, db;
    logic [DW-1:0] exp;
    exp = {4'hB, 124'h0};
    do_reset();
    bus.bitstream_ready = 1'b1;
    wb = words.size();
    db = done_cnt;
    start_stream();
    send(32'h00000005, 6'd3);
    send(32'hFFFFFFF1, 6'd1);
    do_flush();
    repeat (10) @(negedge clk);
    checks++; if (words.size() - wb !== 1) begin fails++;
      $display("FAIL pad_word_count: got %0d want 1", words.size() - wb); end
    else begin
      checks++; if (words[wb] !== exp) begin fails++;
        $display("FAIL pad_word: got %h want %h", words[wb], exp); end
    end
    checks++; if (bit_count !== 32'd4) begin fails++;
      $display("FAIL pad_bit_count: got %0d want 4", bit_count); end
    checks++; if (done_cnt - db !== 1) begin fails++;
      $display("FAIL pad_done_count: got %0d want 1", done_cnt - db); end
    checks++; if (done_cyc !== hs_cyc + 2) begin fails++;
      $display("FAIL pad_done_timing: done seen at %0d want %0d", done_cyc, hs_cyc + 2); end
    checks++; if (busy !== 1'b0) begin fails++;
      $display("FAIL pad_busy: got %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp [3];
    logic [DW-1:0] held;
    int            unstable, wb;
    bit            seen;
    exp[0] = 128'h01010101_02020202_03030303_04040404;
    exp[1] = 128'h05050505_06060606_07070707_08080808;
    exp[2] = 128'h09090909_0A0A0A0A_0B0B0B0B_0C0C0C0C;
    do_reset();
    wb = words.size();
    held = '0;
    start_stream();
    fork
      begin
        for (int i = 0; i < 12; i++) send({4{8'(i + 1)}}, 6'd32);
      end
      begin
        unstable = 0;
        seen     = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (bus.bitstream_valid) begin
            if (!seen) begin
              held = bus.bitstream_data;
              seen = 1'b1;
            end else if (bus.bitstream_data !== held) begin
              unstable++;
            end
          end
        end
        checks++; if (!seen || held !== exp[0]) begin fails++;
          $display("FAIL bp_held_word: got %h want %h", held, exp[0]); end
        checks++; if (unstable !== 0) begin fails++;
          $display("FAIL bp_stable: %0d changes want 0", unstable); end
        checks++; if (bus.symbol_ready !== 1'b0) begin fails++;
          $display("FAIL bp_symbol_ready: got %0b want 0", bus.symbol_ready); end
        bus.bitstream_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    checks++; if (words.size() - wb !== 3) begin fails++;
      $display("FAIL bp_word_count: got %0d want 3", words.size() - wb); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (words[wb + k] !== exp[k]) begin fails++;
          $display("FAIL bp_word%0d: got %h want %h", k, words[wb + k], exp[k]); end
      end
    end
    checks++; if (bit_count !== 32'd384) begin fails++;
      $display("FAIL bp_bit_count: got %0d want 384", bit_count); end
  endtask

  task automatic test_len_clamp();
    int wb, db;
    logic [DW-1:0] exp;
    exp = {36'hF_0000_ABCD, 92'h0};
    do_reset();
    bus.bitstream_ready = 1'b1;
    wb = words.size();
    db = done_cnt;
    start_stream();
    send(32'hFFFFFFFF, 6'd4);
    send(32'h0000ABCD, 6'd40);
    do_flush();
    repeat (10) @(negedge clk);
    checks++; if (words.size() - wb !== 1) begin fails++;
      $display("FAIL clamp_word_count: got %0d want 1", words.size() - wb); end
    else begin
      checks++; if (words[wb] !== exp) begin fails++;
        $display("FAIL clamp_word: got %h want %h", words[wb], exp); end
    end
    checks++; if (bit_count !== 32'd36) begin fails++;
      $display("FAIL clamp_bit_count: got %0d want 36", bit_count); end
    checks++; if (done_cnt - db !== 1) begin fails++;
      $display("FAIL clamp_done_count: got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_empty_flush();
    int wb, db;
    do_reset();
    bus.bitstream_ready = 1'b1;
    wb = words.size();
    db = done_cnt;
    start_stream();
    do_flush();
    repeat (8) @(negedge clk);
    checks++; if (words.size() - wb !== 0) begin fails++;
      $display("FAIL empty_word_count: got %0d want 0", words.size() - wb); end
    checks++; if (done_cnt - db !== 1) begin fails++;
      $display("FAIL empty_done_count: got %0d want 1", done_cnt - db); end
    checks++; if (done_cyc !== flush_cyc + 2) begin fails++;
      $display("FAIL empty_done_timing: done seen at %0d want %0d", done_cyc, flush_cyc + 2); end
    checks++; if (bit_count !== 32'd0) begin fails++;
      $display("FAIL empty_bit_count: got %0d want 0", bit_count); end
  endtask

  task automatic test_reset_mid_stream();
    int wb;
    do_reset();
    start_stream();
    send(32'h11111111, 6'd32);
    send(32'h22222222, 6'd32);
    send(32'h33333333, 6'd32);
    send(32'h44444444, 6'd32);
    send(32'hDEADBEEF, 6'd32);
    @(negedge clk);
    checks++; if (bus.bitstream_valid !== 1'b1) begin fails++;
      $display("FAIL mid_pending: valid %0b want 1", bus.bitstream_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.bitstream_valid !== 1'b0 || bus.bitstream_data !== '0) begin fails++;
      $display("FAIL mid_rst_out: valid %0b data %h want 0/0", bus.bitstream_valid,
               bus.bitstream_data); end
    checks++; if (bus.symbol_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++;
      $display("FAIL mid_rst_ctrl: ready %0b busy %0b done %0b want 0", bus.symbol_ready, busy,
               done); end
    checks++; if (bit_count !== 32'd0) begin fails++;
      $display("FAIL mid_rst_bit_count: got %0d want 0", bit_count); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.bitstream_ready = 1'b1;
    @(negedge clk);
    wb = words.size();
    start_stream();
    send(32'h11111111, 6'd32);
    send(32'h22222222, 6'd32);
    send(32'h33333333, 6'd32);
    send(32'h44444444, 6'd32);
    repeat (5) @(negedge clk);
    checks++; if (words.size() - wb !== 1) begin fails++;
      $display("FAIL mid_word_count: got %0d want 1", words.size() - wb); end
    else begin
      checks++; if (words[wb] !== W1) begin fails++;
        $display("FAIL mid_word: got %h want %h", words[wb], W1); end
    end
    checks++; if (bit_count !== 32'd128) begin fails++;
      $display("FAIL mid_bit_count: got %0d want 128", bit_count); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_pad();
    test_backpressure();
    test_len_clamp();
    test_empty_flush();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
